load_buffer: RTL and testbench

- Tracks outstanding loads between the load unit and the write-through data cache (WT dcache, sv32 FPGA configuration).
- Allocates a buffer ID per load request and records the scoreboard transaction ID, byte offset, size and signedness.
- On the cache response, aligns and extends the data, then emits a one-cycle writeback to the scoreboard.
- Absorbs responses for loads that were killed or flushed.

---
 rtl/load_buffer.sv | 183 ++++++++++++++++++
 tb/tb_load_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_buffer.sv
// load_buffer: tracks outstanding loads between the load unit and the
// write-through data cache. Each accepted load gets a buffer entry holding
// its scoreboard transaction ID, byte offset, size and signedness. When the
// cache answers, the raw word is shifted down to the addressed byte, then
// zero- or sign-extended. The result goes back to the scoreboard as a
// registered single-cycle writeback. Responses for killed or flushed loads
// free their entry and are dropped.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                kill every pending load, block allocation
//   alloc_*                load request (trans id, offset, size, signed);
//                          alloc_ready_o / alloc_id_o report the free entry
//   kill_valid_i/kill_id_i kill one pending load
//   rsp_valid_i/rsp_id_i/rsp_data_i   cache response
//   wb_valid_o/wb_trans_id_o/wb_data_o registered writeback pulse
//   empty_o                no entry allocated
//   err_o                  sticky: response for an unallocated entry
module load_buffer #(
    parameter int unsigned NrEntries    = 2,
    parameter int unsigned TransIdWidth = 2,
    parameter int unsigned XLEN         = 32,
    localparam int unsigned IdWidth     = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    alloc_valid_i,
    output logic                    alloc_ready_o,
    input  logic [TransIdWidth-1:0] alloc_trans_id_i,
    input  logic [1:0]              alloc_offset_i,
    input  logic [1:0]              alloc_size_i,
    input  logic                    alloc_signed_i,
    output logic [IdWidth-1:0]      alloc_id_o,
    input  logic                    kill_valid_i,
    input  logic [IdWidth-1:0]      kill_id_i,
    input  logic                    rsp_valid_i,
    input  logic [IdWidth-1:0]      rsp_id_i,
    input  logic [XLEN-1:0]         rsp_data_i,
    output logic                    wb_valid_o,
    output logic [TransIdWidth-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic                    empty_o,
    output logic                    err_o
);

    logic [NrEntries-1:0]    valid_q, valid_d;
    logic [NrEntries-1:0]    killed_q, killed_d;
    logic [TransIdWidth-1:0] trans_id_q [NrEntries];
    logic [TransIdWidth-1:0] trans_id_d [NrEntries];
    logic [1:0]              offset_q [NrEntries];
    logic [1:0]              offset_d [NrEntries];
    logic [1:0]              size_q [NrEntries];
    logic [1:0]              size_d [NrEntries];
    logic [NrEntries-1:0]    signed_q, signed_d;

    logic                    wb_valid_q, wb_valid_d;
    logic [TransIdWidth-1:0] wb_trans_id_q, wb_trans_id_d;
    logic [XLEN-1:0]         wb_data_q, wb_data_d;
    logic                    err_q, err_d;

    logic                    any_free;
    logic [IdWidth-1:0]      free_id;
    logic                    alloc_fire;
    logic                    kill_hits_rsp;
    logic [XLEN-1:0]         shifted;
    logic                    ext_sign;
    logic [XLEN-1:0]         extended;

    // Lowest-index free entry; only registered state is used so an entry
    // freed by a response this cycle is not handed out until the next one.
    always_comb begin
        any_free = 1'b0;
        free_id  = '0;
        for (int i = int'(NrEntries) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_id  = IdWidth'(i);
            end
        end
    end

    assign alloc_ready_o = ~flush_i & any_free;
    assign alloc_id_o    = free_id;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign kill_hits_rsp = kill_valid_i & (kill_id_i == rsp_id_i);

    // Align the addressed byte to bit 0, then extend according to size.
    always_comb begin
        shifted  = rsp_data_i >> {offset_q[rsp_id_i], 3'b000};
        ext_sign = 1'b0;
        extended = shifted;
        case (size_q[rsp_id_i])
            2'b00: begin
                ext_sign = signed_q[rsp_id_i] & shifted[7];
                extended = {{(XLEN-8){ext_sign}}, shifted[7:0]};
            end
            2'b01: begin
                ext_sign = signed_q[rsp_id_i] & shifted[15];
                extended = {{(XLEN-16){ext_sign}}, shifted[15:0]};
            end
            default: extended = shifted;
        endcase
    end

    always_comb begin
        valid_d       = valid_q;
        killed_d      = killed_q;
        trans_id_d    = trans_id_q;
        offset_d      = offset_q;
        size_d        = size_q;
        signed_d      = signed_q;
        err_d         = err_q;
        wb_valid_d    = 1'b0;
        wb_trans_id_d = '0;
        wb_data_d     = '0;

        if (flush_i) begin
            killed_d = killed_q | valid_q;
        end
        if (kill_valid_i && valid_q[kill_id_i]) begin
            killed_d[kill_id_i] = 1'b1;
        end

        if (rsp_valid_i) begin
            if (!valid_q[rsp_id_i]) begin
                err_d = 1'b1;
            end else begin
                if (!killed_q[rsp_id_i] && !flush_i && !kill_hits_rsp) begin
                    wb_valid_d    = 1'b1;
                    wb_trans_id_d = trans_id_q[rsp_id_i];
                    wb_data_d     = extended;
                end
                valid_d[rsp_id_i]  = 1'b0;
                killed_d[rsp_id_i] = 1'b0;
            end
        end

        // The granted entry was free in registered state, so it can never
        // collide with the entry a live response is freeing.
        if (alloc_fire) begin
            valid_d[free_id]    = 1'b1;
            killed_d[free_id]   = 1'b0;
            trans_id_d[free_id] = alloc_trans_id_i;
            offset_d[free_id]   = alloc_offset_i;
            size_d[free_id]     = alloc_size_i;
            signed_d[free_id]   = alloc_signed_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q       <= '0;
            killed_q      <= '0;
            trans_id_q    <= '{default: '0};
            offset_q      <= '{default: '0};
            size_q        <= '{default: '0};
            signed_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_trans_id_q <= '0;
            wb_data_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            killed_q      <= killed_d;
            trans_id_q    <= trans_id_d;
            offset_q      <= offset_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            wb_valid_q    <= wb_valid_d;
            wb_trans_id_q <= wb_trans_id_d;
            wb_data_q     <= wb_data_d;
            err_q         <= err_d;
        end
    end

    assign wb_valid_o    = wb_valid_q;
    assign wb_trans_id_o = wb_trans_id_q;
    assign wb_data_o     = wb_data_q;
    assign empty_o       = ~|valid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_load_buffer.sv
// Bench for load_buffer: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the outstanding-load table.
module tb_load_buffer;

    localparam int NR = 2;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [1:0]  alloc_trans_id_i;
    logic [1:0]  alloc_offset_i;
    logic [1:0]  alloc_size_i;
    logic        alloc_signed_i;
    logic [0:0]  alloc_id_o;
    logic        kill_valid_i;
    logic [0:0]  kill_id_i;
    logic        rsp_valid_i;
    logic [0:0]  rsp_id_i;
    logic [31:0] rsp_data_i;
    logic        wb_valid_o;
    logic [1:0]  wb_trans_id_o;
    logic [31:0] wb_data_o;
    logic        empty_o;
    logic        err_o;

    load_buffer #(.NrEntries(2), .TransIdWidth(2), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_trans_id_i(alloc_trans_id_i), .alloc_offset_i(alloc_offset_i),
        .alloc_size_i(alloc_size_i), .alloc_signed_i(alloc_signed_i),
        .alloc_id_o(alloc_id_o), .kill_valid_i(kill_valid_i),
        .kill_id_i(kill_id_i), .rsp_valid_i(rsp_valid_i), .rsp_id_i(rsp_id_i),
        .rsp_data_i(rsp_data_i), .wb_valid_o(wb_valid_o),
        .wb_trans_id_o(wb_trans_id_o), .wb_data_o(wb_data_o),
        .empty_o(empty_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: one record per buffer slot
    bit          mv [NR];
    bit          mk [NR];
    int          mt [NR];
    int          moff [NR];
    int          msz [NR];
    bit          msg [NR];
    bit          merr;
    bit          ewb;
    int          etid;
    logic [31:0] edata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] d, input int off,
                                            input int sz, input bit sg);
        longint w;
        w = longint'(d >> (8 * off));
        if (sz == 0) begin
            w = w % 256;
            if (sg && w >= 128) w = w - 256;
        end else if (sz == 1) begin
            w = w % 65536;
            if (sg && w >= 32768) w = w - 65536;
        end
        return w[31:0];
    endfunction

    function automatic bit model_empty();
        for (int i = 0; i < NR; i++) if (mv[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mv[i] = 0; mk[i] = 0; mt[i] = 0; moff[i] = 0; msz[i] = 0; msg[i] = 0;
        end
        merr = 0;
        ewb  = 0;
    endtask

    task automatic clear_inputs();
        flush_i = 0; alloc_valid_i = 0; kill_valid_i = 0; rsp_valid_i = 0;
        alloc_trans_id_i = '0; alloc_offset_i = '0; alloc_size_i = '0;
        alloc_signed_i = 0; kill_id_i = '0; rsp_id_i = '0; rsp_data_i = '0;
    endtask

    // Called shortly after a rising edge with inputs already set; checks the
    // combinational grant, advances the model, then checks registered outputs.
    task automatic drive_cycle();
        int grant;
        bit exp_ready;
        int e;
        #1;
        grant = -1;
        for (int i = NR - 1; i >= 0; i--) if (!mv[i]) grant = i;
        exp_ready = !flush_i && (grant >= 0);
        chk("alloc_ready", {31'b0, alloc_ready_o}, {31'b0, exp_ready});
        if (exp_ready) chk("alloc_id", {31'b0, alloc_id_o}, grant);

        ewb = 0;
        if (flush_i)
            for (int i = 0; i < NR; i++) if (mv[i]) mk[i] = 1;
        if (kill_valid_i && mv[kill_id_i]) mk[kill_id_i] = 1;
        if (rsp_valid_i) begin
            e = int'(rsp_id_i);
            if (!mv[e]) merr = 1;
            else begin
                if (!mk[e]) begin
                    ewb   = 1;
                    etid  = mt[e];
                    edata = ref_ext(rsp_data_i, moff[e], msz[e], msg[e]);
                end
                mv[e] = 0;
                mk[e] = 0;
            end
        end
        if (alloc_valid_i && exp_ready) begin
            mv[grant] = 1; mk[grant] = 0;
            mt[grant] = int'(alloc_trans_id_i);
            moff[grant] = int'(alloc_offset_i);
            msz[grant] = int'(alloc_size_i);
            msg[grant] = alloc_signed_i;
        end

        @(posedge clk_i);
        #1;
        chk("wb_valid", {31'b0, wb_valid_o}, {31'b0, ewb});
        if (ewb) begin
            chk("wb_trans_id", {30'b0, wb_trans_id_o}, etid);
            chk("wb_data", wb_data_o, edata);
        end
        chk("empty", {31'b0, empty_o}, {31'b0, model_empty()});
        chk("err", {31'b0, err_o}, {31'b0, merr});
        clear_inputs();
    endtask

    task automatic do_alloc(input int tid, input int off, input int sz, input bit sg);
        alloc_valid_i = 1; alloc_trans_id_i = 2'(tid);
        alloc_offset_i = 2'(off); alloc_size_i = 2'(sz); alloc_signed_i = sg;
    endtask

    task automatic do_rsp(input int id, input logic [31:0] data);
        rsp_valid_i = 1; rsp_id_i = 1'(id); rsp_data_i = data;
    endtask

    initial begin
        int pick;
        clear_inputs();
        model_reset();
        rst_ni = 0;
        #12;
        chk("rst_empty", {31'b0, empty_o}, 32'd1);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
        chk("rst_wb_tid", {30'b0, wb_trans_id_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_ready", {31'b0, alloc_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1;

        // basic word load
        do_alloc(3, 0, 2, 0); drive_cycle();
        do_rsp(0, 32'hDEADBEEF); drive_cycle();
        chk("word_tid", {30'b0, wb_trans_id_o}, 32'd3);
        chk("word_data", wb_data_o, 32'hDEADBEEF);
        drive_cycle();
        chk("wb_pulse_drop", {31'b0, wb_valid_o}, 32'd0);

        // alignment / extension
        do_alloc(1, 3, 0, 1); drive_cycle();
        do_rsp(0, 32'h80FF_1234); drive_cycle();
        chk("sbyte_off3", wb_data_o, 32'hFFFFFF80);
        do_alloc(1, 3, 0, 0); drive_cycle();
        do_rsp(0, 32'h80FF_1234); drive_cycle();
        chk("ubyte_off3", wb_data_o, 32'h00000080);
        do_alloc(2, 2, 1, 1); drive_cycle();
        do_rsp(0, 32'h80FF_1234); drive_cycle();
        chk("shalf_off2", wb_data_o, 32'hFFFF80FF);

        // full buffer, no same-cycle reuse, out-of-order return
        do_alloc(0, 0, 2, 0); drive_cycle();
        do_alloc(1, 0, 2, 0); drive_cycle();
        do_alloc(2, 0, 2, 0); do_rsp(1, 32'h1111_1111); drive_cycle();
        chk("full_rsp_tid", {30'b0, wb_trans_id_o}, 32'd1);
        do_alloc(2, 0, 2, 0); drive_cycle();
        do_rsp(0, 32'h2222_2222); drive_cycle();
        chk("ooo_tid0", {30'b0, wb_trans_id_o}, 32'd0);
        do_rsp(1, 32'h3333_3333); drive_cycle();
        chk("ooo_tid2", {30'b0, wb_trans_id_o}, 32'd2);

        // flush absorbs both pending loads
        do_alloc(1, 0, 2, 0); drive_cycle();
        do_alloc(2, 0, 2, 0); drive_cycle();
        flush_i = 1; drive_cycle();
        do_rsp(0, 32'hAAAA_0000); drive_cycle();
        do_rsp(1, 32'hBBBB_0000); drive_cycle();
        chk("flush_empty", {31'b0, empty_o}, 32'd1);
        chk("flush_err", {31'b0, err_o}, 32'd0);

        // kill with same-cycle response, and kill ahead of response
        do_alloc(1, 0, 2, 0); drive_cycle();
        do_alloc(2, 0, 2, 0); drive_cycle();
        kill_valid_i = 1; kill_id_i = 1'b0; do_rsp(0, 32'hCAFE_0000); drive_cycle();
        chk("kill_same_wb", {31'b0, wb_valid_o}, 32'd0);
        kill_valid_i = 1; kill_id_i = 1'b1; drive_cycle();
        do_rsp(1, 32'hCAFE_0001); drive_cycle();
        chk("kill_late_wb", {31'b0, wb_valid_o}, 32'd0);
        chk("kill_empty", {31'b0, empty_o}, 32'd1);

        // randomized traffic (responses only to live entries)
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1)
                do_alloc(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                kill_valid_i = 1; kill_id_i = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 19) == 0) flush_i = 1;
            if ($urandom_range(0, 1) == 1) begin
                pick = int'($urandom_range(0, NR - 1));
                if (!mv[pick]) pick = NR - 1 - pick;
                if (mv[pick]) do_rsp(pick, $urandom);
            end
            drive_cycle();
        end
        for (int c = 0; c < NR; c++) begin
            if (mv[c]) begin
                do_rsp(c, $urandom);
                drive_cycle();
            end
        end

        // asynchronous reset mid-operation, then a stale response
        do_alloc(2, 1, 0, 1); drive_cycle();
        #2;
        rst_ni = 0;
        #1;
        chk("async_rst_empty", {31'b0, empty_o}, 32'd1);
        chk("async_rst_wb", {31'b0, wb_valid_o}, 32'd0);
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1;
        do_rsp(0, 32'h1234_5678); drive_cycle();
        chk("stale_err", {31'b0, err_o}, 32'd1);
        chk("stale_wb", {31'b0, wb_valid_o}, 32'd0);
        for (int c = 0; c < 3; c++) drive_cycle();
        chk("err_sticky", {31'b0, err_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
